stdp_weight_engine: RTL and testbench



---
 rtl/stdp_weight_engine_pkg.sv | 15 +
 rtl/stdp_weight_engine_if.sv | 39 +++
 rtl/stdp_weight_engine_dw_calc.sv | 33 +++
 rtl/stdp_weight_engine.sv | 161 ++++++++++++++++
 tb/tb_stdp_weight_engine.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/stdp_weight_engine_pkg.sv
// Shared types and default sizes for the STDP weight engine.
// The FSM walks one presynaptic channel per cycle between IDLE and DONE.
package stdp_weight_engine_pkg;

  localparam int unsigned NDef      = 32;
  localparam int unsigned NumPreDef = 4;
  localparam int unsigned TWDef     = 16;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } stdp_state_t;

endpackage

// File: rtl/stdp_weight_engine_if.sv
// Control, learning-parameter and status signals of the STDP weight engine.
// The master drives stimulus and parameters; the slave (engine) drives weights and status.
interface stdp_weight_engine_if
  import stdp_weight_engine_pkg::*;
#(
  parameter int unsigned N       = NDef,
  parameter int unsigned NUM_PRE = NumPreDef,
  parameter int unsigned T_W     = TWDef
);
  logic                   apply;
  logic                   enable_stdp;
  logic                   load;
  logic [NUM_PRE-1:0]     pre_spike;
  logic                   post_spike;
  logic [N-1:0]           weight_init;
  logic [N-1:0]           w_max;
  logic [N-1:0]           m1;
  logic [N-1:0]           b1;
  logic [N-1:0]           m2;
  logic [N-1:0]           b2;
  logic [NUM_PRE*N-1:0]   weights;
  logic [T_W-1:0]         timestep;
  logic                   rollover;
  logic                   busy;
  logic                   update_done;
  logic                   overrun;

  modport master (
    output apply, enable_stdp, load, pre_spike, post_spike,
    output weight_init, w_max, m1, b1, m2, b2,
    input  weights, timestep, rollover, busy, update_done, overrun
  );

  modport slave (
    input  apply, enable_stdp, load, pre_spike, post_spike,
    input  weight_init, w_max, m1, b1, m2, b2,
    output weights, timestep, rollover, busy, update_done, overrun
  );
endinterface

// File: rtl/stdp_weight_engine_dw_calc.sv
// Linear STDP window: dw = max(0, b - sat_N(m * age)), zero when not enabled.
// Result is N+1 bits so b minus a negative product never wraps.
module stdp_weight_engine_dw_calc
  import stdp_weight_engine_pkg::*;
#(
  parameter int unsigned N   = NDef,
  parameter int unsigned T_W = TWDef
) (
  input  logic           en_i,
  input  logic [N-1:0]   m_i,
  input  logic [N-1:0]   b_i,
  input  logic [T_W-1:0] age_i,
  output logic [N:0]     dw_o
);

  logic signed [N+T_W:0] prod_full;
  logic        [N-1:0]   prod_sat;
  logic signed [N:0]     diff;

  assign prod_full = $signed(m_i) * $signed({1'b0, age_i});

  always_comb begin
    prod_sat = prod_full[N-1:0];
    // Upper bits must all match the N-bit sign bit, else saturate.
    if (!((&prod_full[N+T_W:N-1]) || (~|prod_full[N+T_W:N-1]))) begin
      prod_sat = prod_full[N+T_W] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  assign diff = $signed({b_i[N-1], b_i}) - $signed({prod_sat[N-1], prod_sat});
  assign dw_o = (!en_i || diff[N]) ? '0 : diff;

endmodule

// File: rtl/stdp_weight_engine.sv
// Pair-based STDP unit: tracks spike ages per channel and, after a latched event,
// updates one channel weight per cycle with clamping to [0, w_max].
module stdp_weight_engine
  import stdp_weight_engine_pkg::*;
#(
  parameter int unsigned N       = NDef,
  parameter int unsigned NUM_PRE = NumPreDef,
  parameter int unsigned T_W     = TWDef
) (
  input  logic                 clk,
  input  logic                 rst,
  stdp_weight_engine_if.slave  bus_io
);

  localparam int unsigned IdxW = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1;

  function automatic logic [T_W-1:0] age_inc(input logic [T_W-1:0] a);
    return (&a) ? a : a + T_W'(1);
  endfunction

  logic [T_W-1:0]     ts_q;
  logic               rollover_q;
  logic [T_W-1:0]     pre_age_q [NUM_PRE];
  logic [NUM_PRE-1:0] pre_valid_q;
  logic [T_W-1:0]     post_age_q;
  logic               post_valid_q;

  stdp_state_t        state_q;
  logic [IdxW-1:0]    idx_q;
  logic [NUM_PRE-1:0] pend_pre_q;
  logic               pend_post_q;
  logic [T_W-1:0]     snap_pre_age_q [NUM_PRE];
  logic [NUM_PRE-1:0] snap_pre_valid_q;
  logic [T_W-1:0]     snap_post_age_q;
  logic               snap_post_valid_q;
  logic [N-1:0]       w_q [NUM_PRE];
  logic               busy_q;
  logic               done_q;
  logic               overrun_q;

  logic               any_spike;
  logic [N:0]         ltp;
  logic [N:0]         ltd;
  logic signed [N+1:0] acc;
  logic signed [N+1:0] wmax_ext;
  logic [N-1:0]       w_new;

  assign any_spike = (|bus_io.pre_spike) | bus_io.post_spike;

  // Age tracking runs on every tick regardless of FSM state or enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q         <= '0;
      rollover_q   <= 1'b0;
      pre_age_q    <= '{default: '0};
      pre_valid_q  <= '0;
      post_age_q   <= '0;
      post_valid_q <= 1'b0;
    end else begin
      rollover_q <= bus_io.apply && (&ts_q);
      if (bus_io.apply) begin
        ts_q <= ts_q + T_W'(1);
        for (int k = 0; k < NUM_PRE; k++) begin
          pre_age_q[k]   <= bus_io.pre_spike[k] ? '0 : age_inc(pre_age_q[k]);
          pre_valid_q[k] <= pre_valid_q[k] | bus_io.pre_spike[k];
        end
        post_age_q   <= bus_io.post_spike ? '0 : age_inc(post_age_q);
        post_valid_q <= post_valid_q | bus_io.post_spike;
      end
    end
  end

  stdp_weight_engine_dw_calc #(.N(N), .T_W(T_W)) u_ltp (
    .en_i  (pend_post_q & snap_pre_valid_q[idx_q]),
    .m_i   (bus_io.m1),
    .b_i   (bus_io.b1),
    .age_i (snap_pre_age_q[idx_q]),
    .dw_o  (ltp)
  );

  stdp_weight_engine_dw_calc #(.N(N), .T_W(T_W)) u_ltd (
    .en_i  (pend_pre_q[idx_q] & snap_post_valid_q),
    .m_i   (bus_io.m2),
    .b_i   (bus_io.b2),
    .age_i (snap_post_age_q),
    .dw_o  (ltd)
  );

  always_comb begin
    acc      = $signed({{2{w_q[idx_q][N-1]}}, w_q[idx_q]}) + $signed({1'b0, ltp})
             - $signed({1'b0, ltd});
    wmax_ext = $signed({{2{bus_io.w_max[N-1]}}, bus_io.w_max});
    w_new    = acc[N-1:0];
    if (acc < 0)             w_new = '0;
    else if (acc > wmax_ext) w_new = bus_io.w_max;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StIdle;
      idx_q             <= '0;
      pend_pre_q        <= '0;
      pend_post_q       <= 1'b0;
      snap_pre_age_q    <= '{default: '0};
      snap_pre_valid_q  <= '0;
      snap_post_age_q   <= '0;
      snap_post_valid_q <= 1'b0;
      w_q               <= '{default: '0};
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      overrun_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus_io.apply && (state_q != StIdle)) overrun_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (bus_io.apply) begin
            if (bus_io.enable_stdp && any_spike) begin
              pend_pre_q        <= bus_io.pre_spike;
              pend_post_q       <= bus_io.post_spike;
              for (int k = 0; k < NUM_PRE; k++) snap_pre_age_q[k] <= age_inc(pre_age_q[k]);
              snap_pre_valid_q  <= pre_valid_q;
              snap_post_age_q   <= age_inc(post_age_q);
              snap_post_valid_q <= post_valid_q;
              idx_q             <= '0;
              busy_q            <= 1'b1;
              state_q           <= StScan;
            end
          end else if (bus_io.load) begin
            w_q <= '{default: bus_io.weight_init};
          end
        end
        StScan: begin
          w_q[idx_q] <= w_new;
          if (idx_q == IdxW'(NUM_PRE - 1)) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_PRE; k++) begin : g_wout
    assign bus_io.weights[k*N +: N] = w_q[k];
  end

  assign bus_io.timestep    = ts_q;
  assign bus_io.rollover    = rollover_q;
  assign bus_io.busy        = busy_q;
  assign bus_io.update_done = done_q;
  assign bus_io.overrun     = overrun_q;

endmodule

// File: tb/tb_stdp_weight_engine.sv
// Directed bench: each scan's expected weights and completion cycle go into a queue;
// a negedge monitor pops and compares whenever update_done is seen.
module tb_stdp_weight_engine;

  localparam int unsigned N       = 32;
  localparam int unsigned NUM_PRE = 4;
  localparam int unsigned T_W     = 16;

  typedef struct {
    logic [NUM_PRE*N-1:0] w;
    int                   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   roll_cnt = 0;
  exp_t exp_q[$];

  stdp_weight_engine_if #(.N(N), .NUM_PRE(NUM_PRE), .T_W(T_W)) bus ();

  stdp_weight_engine #(.N(N), .NUM_PRE(NUM_PRE), .T_W(T_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [NUM_PRE*N-1:0] pack(input logic [N-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rollover) roll_cnt++;
    if (!rst && bus.update_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: update_done at cycle %0d with no scan pending", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("scan_weights", bus.weights, e.w);
        check("done_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still %0b expected 0", bus.busy);
    end
    @(negedge clk);
  endtask

  // One timestep tick; when a scan is expected its result is queued.
  task automatic tick(input logic [NUM_PRE-1:0] pre, input logic post, input logic scan,
                      input logic [NUM_PRE*N-1:0] exp_w);
    @(negedge clk);
    bus.apply      = 1'b1;
    bus.pre_spike  = pre;
    bus.post_spike = post;
    if (scan) exp_q.push_back('{w: exp_w, cyc: cyc + 1 + NUM_PRE});
    @(negedge clk);
    bus.apply      = 1'b0;
    bus.pre_spike  = '0;
    bus.post_spike = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [N-1:0] val);
    @(negedge clk);
    bus.load        = 1'b1;
    bus.weight_init = val;
    @(negedge clk);
    bus.load = 1'b0;
    check("load", bus.weights, pack(val, val, val, val));
  endtask

  localparam logic [N-1:0] W0 = 32'h0001_0000;
  logic [NUM_PRE*N-1:0] base;

  initial begin
    bus.apply       = 1'b0;
    bus.enable_stdp = 1'b1;
    bus.load        = 1'b0;
    bus.pre_spike   = '0;
    bus.post_spike  = 1'b0;
    bus.weight_init = '0;
    bus.w_max       = 32'h0001_8000;
    bus.m1          = 32'h0000_1000;
    bus.b1          = 32'h0000_8000;
    bus.m2          = 32'h0000_1000;
    bus.b2          = 32'h0000_8000;
    base            = pack(W0, W0, W0, W0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_weights", bus.weights, '0);
    check("reset_timestep", 128'(bus.timestep), 0);
    check("reset_flags", {bus.busy, bus.update_done, bus.overrun, bus.rollover}, 0);

    // LTP: pre0, two empty ticks, post -> pre age 3 -> +0x5000
    do_load(W0);
    tick(4'b0001, 1'b0, 1'b1, base);
    tick(4'b0000, 1'b0, 1'b0, base);
    tick(4'b0000, 1'b0, 1'b0, base);
    tick(4'b0000, 1'b1, 1'b1, pack(32'h0001_5000, W0, W0, W0));

    // LTD: post, empty tick, pre1 -> post age 2 -> -0x6000
    do_reset();
    do_load(W0);
    tick(4'b0000, 1'b1, 1'b1, base);
    tick(4'b0000, 1'b0, 1'b0, base);
    tick(4'b0010, 1'b0, 1'b1, pack(W0, 32'h0000_A000, W0, W0));

    // Clamp: two posts after pre0 (+0x7000 then +0x6000) saturate at w_max
    do_reset();
    do_load(W0);
    tick(4'b0001, 1'b0, 1'b1, base);
    tick(4'b0000, 1'b1, 1'b1, pack(32'h0001_7000, W0, W0, W0));
    tick(4'b0000, 1'b1, 1'b1, pack(32'h0001_8000, W0, W0, W0));

    // Window edge: post at pre age 9 contributes nothing
    do_reset();
    do_load(W0);
    tick(4'b0001, 1'b0, 1'b1, base);
    for (int i = 0; i < 8; i++) tick(4'b0000, 1'b0, 1'b0, base);
    tick(4'b0000, 1'b1, 1'b1, base);

    // Same-tick pre and post never pair
    do_reset();
    do_load(W0);
    tick(4'b0001, 1'b1, 1'b1, base);

    // Timestep wrap and age saturation
    do_reset();
    do_load(W0);
    roll_cnt = 0;
    @(negedge clk);
    bus.enable_stdp = 1'b0;
    bus.apply       = 1'b1;
    bus.pre_spike   = 4'b0001;
    @(negedge clk);
    bus.pre_spike   = '0;
    repeat (65535) @(negedge clk);
    bus.apply       = 1'b0;
    bus.enable_stdp = 1'b1;
    @(negedge clk);
    check("wrap_timestep", 128'(bus.timestep), 0);
    check("rollover_count", 128'(roll_cnt), 1);
    check("no_scan_when_disabled", {bus.busy, bus.overrun}, 0);
    tick(4'b0000, 1'b1, 1'b1, base);
    check("timestep_after_wrap", 128'(bus.timestep), 1);

    // Overrun: apply during SCAN is dropped and flagged
    do_reset();
    do_load(W0);
    @(negedge clk);
    bus.apply     = 1'b1;
    bus.pre_spike = 4'b0001;
    exp_q.push_back('{w: base, cyc: cyc + 1 + NUM_PRE});
    @(negedge clk);
    check("busy_after_apply", bus.busy, 1);
    bus.pre_spike  = 4'b1111;
    bus.post_spike = 1'b1;
    @(negedge clk);
    bus.apply      = 1'b0;
    bus.pre_spike  = '0;
    bus.post_spike = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    check("overrun_sticky", bus.overrun, 1);
    check("timestep_counts_busy_apply", 128'(bus.timestep), 2);

    // Reset mid-scan at channel 2
    @(negedge clk);
    bus.apply      = 1'b1;
    bus.post_spike = 1'b1;
    @(negedge clk);
    bus.apply      = 1'b0;
    bus.post_spike = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("rst_weights", bus.weights, '0);
    check("rst_flags", {bus.busy, bus.overrun, bus.update_done}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
